// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one 16-bit address / 8-bit data memory (ROM 0x0000-0x7FFF,
//   RAM 0x8000-0xFFFF) between two requesters and sequences each access
//   through SETUP, STROBE (WAIT_STATES+1 cycles) and HOLD phases.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   REQn/WRITEn/ADDRn/WDATAn request, direction, address, write data (n=0,1)
//   ACKn                     one-cycle completion pulse for port n
//   RDATA                    data of the last completed read
//   GRANT                    one-hot owner of current transaction, 00 idle
//   BUSY                     high whenever the sequencer is not idle
//   ROM_WRITE_ERR            pulses with ACK on a suppressed write to ROM
//   MEM_ADDR/MEM_WDATA       address and write data to the memory
//   MEM_RDATA                read data from the memory
//   MEM_OE_bar/MEM_WE_bar    active-low read / write strobes
//
// Every output comes straight from a flop; the strobe flops are computed
// from the next state so they change on the same edge as the state.
module memory_arbiter #(
  parameter int unsigned WAIT_STATES    = 1,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        WRITE0,
  input  logic [15:0] ADDR0,
  input  logic [7:0]  WDATA0,
  output logic        ACK0,
  input  logic        REQ1,
  input  logic        WRITE1,
  input  logic [15:0] ADDR1,
  input  logic [7:0]  WDATA1,
  output logic        ACK1,
  output logic [7:0]  RDATA,
  output logic [1:0]  GRANT,
  output logic        BUSY,
  output logic        ROM_WRITE_ERR,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  output logic        MEM_OE_bar,
  output logic        MEM_WE_bar
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        write_q, write_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        oe_bar_q, oe_bar_d;
  logic        we_bar_q, we_bar_d;
  logic        win1_s;

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    win1_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          if (REQ0 && REQ1) begin
            // LAST=1 means port 1 won previously, so port 0 goes next.
            win1_s = FIXED_PRIORITY ? 1'b0 : ~last_q;
          end else begin
            win1_s = REQ1;
          end
          last_d      = win1_s;
          grant_d     = win1_s ? 2'b10 : 2'b01;
          mem_addr_d  = win1_s ? ADDR1  : ADDR0;
          mem_wdata_d = win1_s ? WDATA1 : WDATA0;
          write_d     = win1_s ? WRITE1 : WRITE0;
          state_d     = ST_SETUP;
        end else begin
          grant_d = 2'b00;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = WAIT_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          if (!write_q) begin
            rdata_d = MEM_RDATA;
          end else begin
            rdata_d = rdata_q;
          end
          ack0_d = grant_q[0];
          ack1_d = grant_q[1];
          err_d  = write_q && !mem_addr_q[15];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Strobes follow the state being entered; a ROM write never pulls WE low.
    busy_d   = (state_d != ST_IDLE);
    oe_bar_d = !((state_d == ST_STROBE) && !write_d);
    we_bar_d = !((state_d == ST_STROBE) && write_d && mem_addr_d[15]);
  end

  // State and output registers, cleared immediately by RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      write_q     <= 1'b0;
      rdata_q     <= 8'h00;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      oe_bar_q    <= 1'b1;
      we_bar_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      oe_bar_q    <= oe_bar_d;
      we_bar_q    <= we_bar_d;
    end
  end

  assign ACK0          = ack0_q;
  assign ACK1          = ack1_q;
  assign RDATA         = rdata_q;
  assign GRANT         = grant_q;
  assign BUSY          = busy_q;
  assign ROM_WRITE_ERR = err_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_WDATA     = mem_wdata_q;
  assign MEM_OE_bar    = oe_bar_q;
  assign MEM_WE_bar    = we_bar_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter. Three instances share all inputs:
//   dut_a: WAIT_STATES=1, round-robin
//   dut_b: WAIT_STATES=0, fixed priority
//   dut_c: WAIT_STATES=3, round-robin
// Latency n counts rising edges with the REQ-sampling edge as edge 1;
// ACK is expected to be seen after edge WAIT_STATES+3.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, write0, req1, write1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1, mem_rdata;

  logic        ack0_a, ack1_a, busy_a, err_a, oe_a, we_a;
  logic [1:0]  grant_a;
  logic [7:0]  rdata_a, mwdata_a;
  logic [15:0] maddr_a;
  logic        ack0_b, ack1_b, busy_b, err_b, oe_b, we_b;
  logic [1:0]  grant_b;
  logic [7:0]  rdata_b, mwdata_b;
  logic [15:0] maddr_b;
  logic        ack0_c, ack1_c, busy_c, err_c, oe_c, we_c;
  logic [1:0]  grant_c;
  logic [7:0]  rdata_c, mwdata_c;
  logic [15:0] maddr_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.WAIT_STATES(1), .FIXED_PRIORITY(1'b0)) dut_a (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .WRITE0(write0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(ack0_a),
    .REQ1(req1), .WRITE1(write1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(ack1_a),
    .RDATA(rdata_a), .GRANT(grant_a), .BUSY(busy_a), .ROM_WRITE_ERR(err_a),
    .MEM_ADDR(maddr_a), .MEM_WDATA(mwdata_a), .MEM_RDATA(mem_rdata),
    .MEM_OE_bar(oe_a), .MEM_WE_bar(we_a));

  memory_arbiter #(.WAIT_STATES(0), .FIXED_PRIORITY(1'b1)) dut_b (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .WRITE0(write0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(ack0_b),
    .REQ1(req1), .WRITE1(write1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(ack1_b),
    .RDATA(rdata_b), .GRANT(grant_b), .BUSY(busy_b), .ROM_WRITE_ERR(err_b),
    .MEM_ADDR(maddr_b), .MEM_WDATA(mwdata_b), .MEM_RDATA(mem_rdata),
    .MEM_OE_bar(oe_b), .MEM_WE_bar(we_b));

  memory_arbiter #(.WAIT_STATES(3), .FIXED_PRIORITY(1'b0)) dut_c (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .WRITE0(write0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(ack0_c),
    .REQ1(req1), .WRITE1(write1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(ack1_c),
    .RDATA(rdata_c), .GRANT(grant_c), .BUSY(busy_c), .ROM_WRITE_ERR(err_c),
    .MEM_ADDR(maddr_c), .MEM_WDATA(mwdata_c), .MEM_RDATA(mem_rdata),
    .MEM_OE_bar(oe_c), .MEM_WE_bar(we_c));

  // Advance one cycle; sampling happens at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; write0 = 1'b0; addr0 = 16'h0000; wdata0 = 8'h00;
    req1 = 1'b0; write1 = 1'b0; addr1 = 16'h0000; wdata1 = 8'h00;
    mem_rdata = 8'h00;
    tick();
    tick();
    checks++;
    if ({maddr_a, mwdata_a, rdata_a} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h required 0", maddr_a, mwdata_a, rdata_a);
    end
    checks++;
    if ({oe_a, we_a} !== 2'b11) begin
      failures++;
      $display("FAIL reset_strobes oe/we=%b required 11", {oe_a, we_a});
    end
    checks++;
    if ({ack0_a, ack1_a, err_a, busy_a} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags ack0/ack1/err/busy=%b required 0000", {ack0_a, ack1_a, err_a, busy_a});
    end
    checks++;
    if (grant_a !== 2'b00) begin
      failures++;
      $display("FAIL reset_grant grant=%b required 00", grant_a);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int oe_cnt = 0, ack_cnt = 0, ack_n = 0, grant_bad = 0, addr_bad = 0;
    addr0 = 16'h8123; write0 = 1'b0; mem_rdata = 8'h5A; req0 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 2) addr0 = 16'h0000;   // must not disturb the latched access
      if (!oe_a) oe_cnt++;
      if (busy_a && grant_a !== 2'b01) grant_bad++;
      if (busy_a && maddr_a !== 16'h8123) addr_bad++;
      if (ack0_a) begin
        ack_cnt++;
        if (ack_n == 0) ack_n = n;
        req0 = 1'b0;
      end
    end
    checks++;
    if (oe_cnt != 2) begin failures++; $display("FAIL read_oe_width got=%0d required 2", oe_cnt); end
    checks++;
    if (ack_n != 4) begin failures++; $display("FAIL read_ack_latency got=%0d required 4", ack_n); end
    checks++;
    if (ack_cnt != 1) begin failures++; $display("FAIL read_ack_count got=%0d required 1", ack_cnt); end
    checks++;
    if (rdata_a !== 8'h5A) begin failures++; $display("FAIL read_rdata got=%h required 5a", rdata_a); end
    checks++;
    if (grant_bad != 0) begin failures++; $display("FAIL read_grant bad_cycles=%0d required 0", grant_bad); end
    checks++;
    if (addr_bad != 0) begin failures++; $display("FAIL read_addr_stable bad_cycles=%0d required 0", addr_bad); end
  endtask

  task automatic test_ram_write();
    int we_cnt = 0, oe_cnt = 0, ack_cnt = 0, bad = 0;
    logic [15:0] we_mask = 16'h0000;
    addr1 = 16'hC000; wdata1 = 8'hA5; write1 = 1'b1; mem_rdata = 8'hFF; req1 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 2) wdata1 = 8'h00;
      if (!we_a) begin we_cnt++; we_mask[n] = 1'b1; end
      if (!oe_a) oe_cnt++;
      if (busy_a && (grant_a !== 2'b10 || maddr_a !== 16'hC000 || mwdata_a !== 8'hA5)) bad++;
      if (ack0_a) bad++;
      if (ack1_a) begin ack_cnt++; req1 = 1'b0; end
    end
    write1 = 1'b0;
    checks++;
    if (we_cnt != 2) begin failures++; $display("FAIL ramw_we_width got=%0d required 2", we_cnt); end
    checks++;
    if (we_mask !== 16'h000C) begin failures++; $display("FAIL ramw_we_cycles mask=%h required 000c", we_mask); end
    checks++;
    if (oe_cnt != 0) begin failures++; $display("FAIL ramw_oe got=%0d required 0", oe_cnt); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL ramw_bus_stable bad_cycles=%0d required 0", bad); end
    checks++;
    if (ack_cnt != 1) begin failures++; $display("FAIL ramw_ack_count got=%0d required 1", ack_cnt); end
    checks++;
    if (rdata_a !== 8'h5A) begin failures++; $display("FAIL ramw_rdata_kept got=%h required 5a", rdata_a); end
  endtask

  task automatic test_rom_write();
    int we_cnt = 0, ack_cnt = 0, err_cnt = 0, mism = 0;
    addr0 = 16'h1234; wdata0 = 8'h99; write0 = 1'b1; req0 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (!we_a) we_cnt++;
      if (err_a) err_cnt++;
      if (ack0_a !== err_a) mism++;
      if (ack0_a) begin ack_cnt++; req0 = 1'b0; end
    end
    write0 = 1'b0;
    checks++;
    if (we_cnt != 0) begin failures++; $display("FAIL romw_we_low got=%0d required 0", we_cnt); end
    checks++;
    if (ack_cnt != 1) begin failures++; $display("FAIL romw_ack_count got=%0d required 1", ack_cnt); end
    checks++;
    if (err_cnt != 1) begin failures++; $display("FAIL romw_err_count got=%0d required 1", err_cnt); end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL romw_err_with_ack mismatched_cycles=%0d required 0", mism); end
  endtask

  task automatic test_contention();
    int na = 0, nb = 0, b_first = 0, b_second = 0;
    logic [3:0] oa = 4'h0, ob = 4'h0;
    pulse_reset();
    addr0 = 16'h8000; addr1 = 16'h8001; write0 = 1'b0; write1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ack0_a || ack1_a) begin
        if (na < 4) oa[na] = ack1_a;
        na++;
      end
      if (ack0_b || ack1_b) begin
        if (nb < 4) ob[nb] = ack1_b;
        if (nb == 0) b_first = n;
        if (nb == 1) b_second = n;
        nb++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    checks++;
    if (na < 4) begin failures++; $display("FAIL rr_count got=%0d required >=4", na); end
    checks++;
    if (oa !== 4'b1010) begin failures++; $display("FAIL rr_order got=%b required 1010 (bit0 first)", oa); end
    checks++;
    if (nb < 4) begin failures++; $display("FAIL fixed_count got=%0d required >=4", nb); end
    checks++;
    if (ob !== 4'b0000) begin failures++; $display("FAIL fixed_order got=%b required 0000", ob); end
    checks++;
    if (b_second - b_first != 4) begin
      failures++;
      $display("FAIL min_spacing got=%0d required 4", b_second - b_first);
    end
  endtask

  task automatic test_wait_states();
    int ob_cnt = 0, oc_cnt = 0, fb = 0, fc = 0;
    pulse_reset();
    addr0 = 16'h8040; write0 = 1'b0; mem_rdata = 8'h77; req0 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (!oe_b) ob_cnt++;
      if (!oe_c) oc_cnt++;
      if (ack0_b && fb == 0) fb = n;
      if (ack0_c && fc == 0) fc = n;
      if (ack0_b) req0 = 1'b0;
    end
    req0 = 1'b0;
    checks++;
    if (ob_cnt != 1) begin failures++; $display("FAIL ws0_strobe got=%0d required 1", ob_cnt); end
    checks++;
    if (oc_cnt != 4) begin failures++; $display("FAIL ws3_strobe got=%0d required 4", oc_cnt); end
    checks++;
    if (fb != 3) begin failures++; $display("FAIL ws0_latency got=%0d required 3", fb); end
    checks++;
    if (fc != 6) begin failures++; $display("FAIL ws3_latency got=%0d required 6", fc); end
    checks++;
    if (rdata_c !== 8'h77) begin failures++; $display("FAIL ws3_rdata got=%h required 77", rdata_c); end
  endtask

  task automatic test_reset_strobe();
    int waited = 0, ack_seen = 0;
    pulse_reset();
    addr0 = 16'h9000; write0 = 1'b0; mem_rdata = 8'hE1; req0 = 1'b1;
    while (oe_a && waited < 10) begin tick(); waited++; end
    checks++;
    if (oe_a !== 1'b0) begin failures++; $display("FAIL rst_reach_strobe oe=%b required 0", oe_a); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (oe_a !== 1'b1) begin failures++; $display("FAIL rst_async_oe oe=%b required 1", oe_a); end
    checks++;
    if (busy_a !== 1'b0 || grant_a !== 2'b00) begin
      failures++;
      $display("FAIL rst_async_busy busy=%b grant=%b required 0/00", busy_a, grant_a);
    end
    @(negedge clk);
    tick();
    checks++;
    if (ack0_a !== 1'b0 || rdata_a !== 8'h00) begin
      failures++;
      $display("FAIL rst_no_ack ack0=%b rdata=%h required 0/00", ack0_a, rdata_a);
    end
    rst = 1'b0;
    mem_rdata = 8'h3C;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (ack0_a && ack_seen == 0) begin
        ack_seen = n;
        req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    checks++;
    if (ack_seen != 4) begin failures++; $display("FAIL rst_recover_ack got=%0d required 4", ack_seen); end
    checks++;
    if (rdata_a !== 8'h3C) begin failures++; $display("FAIL rst_recover_rdata got=%h required 3c", rdata_a); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single_read();
    test_ram_write();
    test_rom_write();
    test_contention();
    test_wait_states();
    test_reset_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sequences and shares the 16-bit-address / 8-bit-data memory subsystem (ROM at 0x0000-0x7FFF, RAM at 0x8000-0xFFFF) between two requesters: port 0 is CPU, port 1 is DMA/video.
- Generates ADDR/DATA and the active-low OE_bar/WE_bar strobes with setup, strobe and hold phases.
- Captures read data and returns a one-cycle acknowledge.
- Blocks writes to the ROM half and flags them.

Parameters:
- WAIT_STATES, 1: extra strobe cycles; strobe phase lasts WAIT_STATES+1 cycles; legal range 0-15.
- FIXED_PRIORITY, 0: 0 = round-robin between ports; 1 = port 0 always wins a simultaneous request.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- REQ0  input  1  port 0 request; held high until ACK0.
- WRITE0  input  1  port 0 direction: 1 = write, 0 = read.
- ADDR0  input  16  port 0 address.
- WDATA0  input  8  port 0 write data.
- ACK0  output  1  port 0 completion pulse.
- REQ1, WRITE1, ADDR1, WDATA1, ACK1: same as port 0, for port 1.
- RDATA  output  8  read data of the last completed read; valid when ACKn=1.
- GRANT  output  2  one-hot owner of the current transaction; 00 when idle.
- BUSY  output  1  high in any state other than IDLE.
- ROM_WRITE_ERR  output  1  one-cycle pulse, coincident with ACK, on a write to ADDR[15]=0.
- MEM_ADDR  output  16  to memory ADDR_IN.
- MEM_WDATA  output  8  to memory DATA_IN.
- MEM_RDATA  input  8  from memory DATA_OUT.
- MEM_OE_bar  output  1  read strobe, active low.
- MEM_WE_bar  output  1  write strobe, active low.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - MEM_OE_bar=1, MEM_WE_bar=1.
  - MEM_ADDR=0, MEM_WDATA=0, RDATA=0.
  - ACK0/1=0, GRANT=00, BUSY=0, ROM_WRITE_ERR=0.
  - Round-robin pointer LAST=1, so port 0 wins the first contention.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - REQn is sampled only in this state.
  - If any request is pending, select the winner and latch its ADDR/WDATA/WRITE into internal registers.
  - Set GRANT, then go to SETUP.
  - With no request pending, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - Both requesting, FIXED_PRIORITY=1: port 0 wins.
  - Both requesting, FIXED_PRIORITY=0: the port not equal to LAST wins.
  - LAST updates to the winner at grant.
- SETUP (1 cycle):
  - MEM_ADDR and MEM_WDATA are driven from the latches.
  - Both strobes stay high.
  - Next state is STROBE; the wait counter loads WAIT_STATES.
- STROBE (WAIT_STATES+1 cycles):
  - Read: MEM_OE_bar=0.
  - Write to ADDR[15]=1: MEM_WE_bar=0.
  - Write to ADDR[15]=0: both strobes stay high (write suppressed).
  - Only one strobe is ever low.
  - The counter decrements each cycle; at count 0 the state goes to HOLD.
  - For reads, RDATA captures MEM_RDATA on that same edge.
- HOLD (1 cycle):
  - Strobes high; MEM_ADDR/MEM_WDATA unchanged.
  - ACKn=1 for the granted port; ROM_WRITE_ERR=1 if the write was suppressed.
  - Next state is IDLE; GRANT clears on that transition.
- Latency: ACK is asserted WAIT_STATES+3 cycles after the IDLE edge that sampled REQ.
  - Minimum inter-transaction spacing is WAIT_STATES+4 cycles, because one IDLE cycle is mandatory.
  - The requester may drop REQ in the ACK cycle.
  - A REQ still high in IDLE after ACK is a new request.
- Stability: requester inputs are latched at grant. Changes during a transaction have no effect on it.
- RDATA holds its value until the next read completes; writes do not change RDATA.
- All outputs are registered; no combinational path from REQ to the memory pins.
- Reset mid-transaction:
  - Strobes go high asynchronously and the transaction is aborted.
  - No ACK and no RDATA update for the aborted transaction.
  - The FSM restarts in IDLE with LAST=1.

Test Plan:
- Single read, WAIT_STATES=1:
  - Stimulus: REQ0 with ADDR0=0x8123 while MEM_RDATA=0x5A.
  - Response: MEM_OE_bar low for exactly 2 cycles; ACK0 asserted 4 cycles after the sampling edge; RDATA=0x5A; GRANT=01 throughout.
- RAM write:
  - Stimulus: REQ1, WRITE1=1, ADDR1=0xC000, WDATA1=0xA5.
  - Response: MEM_ADDR=0xC000 and MEM_WDATA=0xA5 stable from SETUP through HOLD; MEM_WE_bar low for 2 cycles only in STROBE; ACK1 pulses once; RDATA unchanged.
- ROM write:
  - Stimulus: write to 0x1234.
  - Response: MEM_WE_bar never low; ACK and ROM_WRITE_ERR pulse together.
- Contention:
  - Stimulus: REQ0 and REQ1 both held high for 4 transactions, FIXED_PRIORITY=0.
  - Response: grant order 0,1,0,1.
  - With FIXED_PRIORITY=1: all four grants go to port 0.
- Wait states:
  - Stimulus: WAIT_STATES=0, then 3.
  - Response: strobe width 1 and 4 cycles; ACK latency 3 and 6 cycles.
- Reset during STROBE:
  - Stimulus: assert RST mid-read.
  - Response: MEM_OE_bar high without waiting for a clock edge; no ACK; BUSY=0.
  - After release, a new REQ0 completes normally.
